instr_queue: RTL and testbench

- Dual-lane instruction queue between the dual-issue fetch stage and decode.
- Accepts an instruction pair from fetch, each with its PC and PC+4, and buffers it in a circular FIFO of single-instruction entries.
- Presents the two oldest entries to decode in program order. Decode retires 0, 1 or 2 per cycle, so an intra-pair hazard stalls only lane 2.
- Generates backpressure for the fetch-stage enables and flushes on redirect.

---
 rtl/instr_queue.sv | 185 ++++++++++++++++++
 tb/tb_instr_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
// Dual-lane instruction queue between a dual-issue fetch stage and decode.
// Fetch pushes an instruction pair (each with PC and PC+4). The pair lands in
// two consecutive entries of a circular FIFO of single-instruction entries.
// The two oldest entries are presented to decode in program order. Decode
// retires 0, 1 or 2 entries per cycle.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   PushF, InstrF1/PCF1/PCPlus4F1, InstrF2/PCF2/PCPlus4F2
//                                pair offered by fetch (F1 is older)
//   ReadyF                       at least two free entries (from registered count only)
//   IssueD                       entries consumed by decode (3 behaves as 2)
//   FlushD                       redirect: empty the queue on the next edge
//   InstrD1/PCD1/PCPlus4D1/ValidD1  head entry
//   InstrD2/PCD2/PCPlus4D2/ValidD2  head+1 entry
//   CountQ                       current occupancy
//
// Optional build macro INSTR_QUEUE_BYPASS_EN: when the queue is empty and a
// push happens, F1/F2 are forwarded straight to the D lanes in the same cycle.
// Entries that decode consumes in that cycle are never written to storage.
// ---------------------------------------------------------------------------
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PushF,
  input  logic [XLEN-1:0]          InstrF1,
  input  logic [XLEN-1:0]          PCF1,
  input  logic [XLEN-1:0]          PCPlus4F1,
  input  logic [XLEN-1:0]          InstrF2,
  input  logic [XLEN-1:0]          PCF2,
  input  logic [XLEN-1:0]          PCPlus4F2,
  output logic                     ReadyF,
  input  logic [1:0]               IssueD,
  input  logic                     FlushD,
  output logic [XLEN-1:0]          InstrD1,
  output logic [XLEN-1:0]          PCD1,
  output logic [XLEN-1:0]          PCPlus4D1,
  output logic                     ValidD1,
  output logic [XLEN-1:0]          InstrD2,
  output logic [XLEN-1:0]          PCD2,
  output logic [XLEN-1:0]          PCPlus4D2,
  output logic                     ValidD2,
  output logic [$clog2(DEPTH):0]   CountQ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          bypass;
  logic [1:0]    issue_cap;
  logic [1:0]    pops;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;

  // Write ports: port 0 at tail, port 1 at tail+1. wr0_f2 selects F2 for
  // port 0, used only when a bypassed F1 was consumed immediately.
  logic          wr0_en, wr1_en, wr0_f2;
  logic [PW-1:0] wr0_addr, wr1_addr;

  assign head_p1 = head_q + 1'b1;
  assign tail_p1 = tail_q + 1'b1;

  // Based on registered count only: no decode-to-fetch combinational path.
  assign ReadyF = (count_q <= CW'(DEPTH - 2));
  assign push   = PushF && ReadyF && !FlushD;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = push && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    issue_cap = (IssueD == 2'd3) ? 2'd2 : IssueD;
    // Clip to what is actually valid before the edge.
    if (count_q < CW'(issue_cap)) pops = count_q[1:0];
    else                          pops = issue_cap;
    // A bypassed pair is visible on both lanes, so any issue up to 2 is valid.
    if (bypass) pops = issue_cap;
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_f2   = 1'b0;
    wr0_addr = tail_q;
    wr1_addr = tail_p1;
    if (FlushD) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (bypass) begin
      // Queue was empty: store only the part of the pair decode did not take.
      tail_d  = tail_q + PW'(2'd2 - pops);
      count_d = CW'(2'd2 - pops);
      case (pops)
        2'd0: begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
        end
        2'd1: begin
          wr0_en = 1'b1;
          wr0_f2 = 1'b1;
        end
        default: ;
      endcase
    end else begin
      head_d  = head_q + PW'(pops);
      count_d = count_q - CW'(pops);
      if (push) begin
        wr0_en  = 1'b1;
        wr1_en  = 1'b1;
        tail_d  = tail_q + PW'(2);
        count_d = count_q + CW'(2) - CW'(pops);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      instr_mem[wr0_addr] <= wr0_f2 ? InstrF2   : InstrF1;
      pc_mem[wr0_addr]    <= wr0_f2 ? PCF2      : PCF1;
      pc4_mem[wr0_addr]   <= wr0_f2 ? PCPlus4F2 : PCPlus4F1;
    end
    if (wr1_en) begin
      instr_mem[wr1_addr] <= InstrF2;
      pc_mem[wr1_addr]    <= PCF2;
      pc4_mem[wr1_addr]   <= PCPlus4F2;
    end
  end

  always_comb begin
    ValidD1   = (count_q != '0);
    ValidD2   = (count_q >= CW'(2));
    InstrD1   = ValidD1 ? instr_mem[head_q]  : NOP;
    PCD1      = ValidD1 ? pc_mem[head_q]     : '0;
    PCPlus4D1 = ValidD1 ? pc4_mem[head_q]    : '0;
    InstrD2   = ValidD2 ? instr_mem[head_p1] : NOP;
    PCD2      = ValidD2 ? pc_mem[head_p1]    : '0;
    PCPlus4D2 = ValidD2 ? pc4_mem[head_p1]   : '0;
    if (bypass) begin
      ValidD1   = 1'b1;
      ValidD2   = 1'b1;
      InstrD1   = InstrF1;
      PCD1      = PCF1;
      PCPlus4D1 = PCPlus4F1;
      InstrD2   = InstrF2;
      PCD2      = PCF2;
      PCPlus4D2 = PCPlus4F2;
    end
  end

  assign CountQ = count_q;

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             PushF = 1'b0;
  logic [XLEN-1:0]  InstrF1 = '0, PCF1 = '0, PCPlus4F1 = '0;
  logic [XLEN-1:0]  InstrF2 = '0, PCF2 = '0, PCPlus4F2 = '0;
  logic             ReadyF;
  logic [1:0]       IssueD = 2'd0;
  logic             FlushD = 1'b0;
  logic [XLEN-1:0]  InstrD1, PCD1, PCPlus4D1;
  logic             ValidD1;
  logic [XLEN-1:0]  InstrD2, PCD2, PCPlus4D2;
  logic             ValidD2;
  logic [3:0]       CountQ;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] next_pc = 32'h0;

  instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .PushF(PushF),
    .InstrF1(InstrF1), .PCF1(PCF1), .PCPlus4F1(PCPlus4F1),
    .InstrF2(InstrF2), .PCF2(PCF2), .PCPlus4F2(PCPlus4F2),
    .ReadyF(ReadyF), .IssueD(IssueD), .FlushD(FlushD),
    .InstrD1(InstrD1), .PCD1(PCD1), .PCPlus4D1(PCPlus4D1), .ValidD1(ValidD1),
    .InstrD2(InstrD2), .PCD2(PCD2), .PCPlus4D2(PCPlus4D2), .ValidD2(ValidD2),
    .CountQ(CountQ)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic entry_t mk(input logic [31:0] pc);
    entry_t e;
    e.instr = (pc << 8) | 32'h0000_0033;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    return e;
  endfunction

  // One clock of stimulus. Entries decode consumes are compared against the
  // scoreboard front before the edge; the scoreboard is then updated.
  task automatic drive_cycle(input logic push, input logic [31:0] pc1,
                             input logic [1:0] issue, input logic flush,
                             output bit acc);
    entry_t e1, e2;
    int cap, pops;
    e1 = mk(pc1);
    e2 = mk(pc1 + 32'd4);
    PushF = push;
    InstrF1 = e1.instr; PCF1 = e1.pc; PCPlus4F1 = e1.pc4;
    InstrF2 = e2.instr; PCF2 = e2.pc; PCPlus4F2 = e2.pc4;
    IssueD = issue;
    FlushD = flush;
    #1;
    cap  = (issue == 2'd3) ? 2 : int'(issue);
    pops = (cap < sb.size()) ? cap : sb.size();
    acc  = push && (sb.size() <= DEPTH - 2) && !flush;
    if (!flush && pops >= 1) begin
      checks++;
      if (PCD1 !== sb[0].pc || InstrD1 !== sb[0].instr || PCPlus4D1 !== sb[0].pc4) begin
        errors++;
        $display("FAIL sb_lane1 got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                 PCD1, InstrD1, PCPlus4D1, sb[0].pc, sb[0].instr, sb[0].pc4);
      end
    end
    if (!flush && pops == 2) begin
      checks++;
      if (PCD2 !== sb[1].pc || InstrD2 !== sb[1].instr || PCPlus4D2 !== sb[1].pc4) begin
        errors++;
        $display("FAIL sb_lane2 got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                 PCD2, InstrD2, PCPlus4D2, sb[1].pc, sb[1].instr, sb[1].pc4);
      end
    end
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
    end else begin
      repeat (pops) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(e1);
        sb.push_back(e2);
      end
    end
    PushF = 1'b0;
    IssueD = 2'd0;
    FlushD = 1'b0;
    $display("txn push=%0b pc=%h issue=%0d flush=%0b accepted=%0b count=%0d",
             push, pc1, issue, flush, acc, CountQ);
  endtask

  task automatic push_pair(input logic [1:0] issue);
    bit acc;
    drive_cycle(1'b1, next_pc, issue, 1'b0, acc);
    if (acc) next_pc += 32'd8;
  endtask

  task automatic idle_issue(input logic [1:0] issue);
    bit acc;
    drive_cycle(1'b0, 32'h0, issue, 1'b0, acc);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (ValidD1 !== 1'b0 || ValidD2 !== 1'b0 || ReadyF !== 1'b1 || CountQ !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got v1=%b v2=%b ready=%b count=%0d want 0 0 1 0",
               ValidD1, ValidD2, ReadyF, CountQ);
    end
    checks++;
    if (InstrD1 !== 32'h13 || PCD1 !== 32'h0 || InstrD2 !== 32'h13 || PCPlus4D2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_nop got i1=%h pc1=%h i2=%h pc4_2=%h want 13 0 13 0",
               InstrD1, PCD1, InstrD2, PCPlus4D2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_pair;
    push_pair(2'd0);
    checks++;
    if (ValidD1 !== 1'b1 || ValidD2 !== 1'b1 || PCD1 !== 32'h0 || PCD2 !== 32'h4 ||
        CountQ !== 4'd2 || ReadyF !== 1'b1) begin
      errors++;
      $display("FAIL first_pair got v1=%b v2=%b pc1=%h pc2=%h count=%0d ready=%b want 1 1 0 4 2 1",
               ValidD1, ValidD2, PCD1, PCD2, CountQ, ReadyF);
    end
    checks++;
    if (InstrD1 !== 32'h0000_0033 || PCPlus4D2 !== 32'h8) begin
      errors++;
      $display("FAIL first_pair_fields got i1=%h pc4_2=%h want 00000033 00000008", InstrD1, PCPlus4D2);
    end
  endtask

  task automatic test_fill;
    bit acc;
    repeat (3) push_pair(2'd0);
    checks++;
    if (CountQ !== 4'd8 || ReadyF !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got count=%0d ready=%b want 8 0", CountQ, ReadyF);
    end
    drive_cycle(1'b1, 32'h40, 2'd0, 1'b0, acc);
    checks++;
    if (CountQ !== 4'd8 || PCD1 !== 32'h0) begin
      errors++;
      $display("FAIL fill_ignored got count=%0d pc1=%h want 8 0", CountQ, PCD1);
    end
  endtask

  task automatic test_partial_issue;
    idle_issue(2'd1);
    checks++;
    if (PCD1 !== 32'h4 || PCD2 !== 32'h8 || CountQ !== 4'd7 || ReadyF !== 1'b0) begin
      errors++;
      $display("FAIL issue1 got pc1=%h pc2=%h count=%0d ready=%b want 4 8 7 0",
               PCD1, PCD2, CountQ, ReadyF);
    end
    idle_issue(2'd2);
    checks++;
    if (CountQ !== 4'd5 || ReadyF !== 1'b1 || PCD1 !== 32'hC) begin
      errors++;
      $display("FAIL issue2 got count=%0d ready=%b pc1=%h want 5 1 c", CountQ, ReadyF, PCD1);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] prev;
    for (int i = 0; i < 10; i++) begin
      prev = PCD1;
      push_pair(2'd2);
      checks++;
      if (CountQ !== 4'd5 || PCD1 !== prev + 32'd8 || PCD1 !== sb[0].pc) begin
        errors++;
        $display("FAIL wrap_%0d got count=%0d pc1=%h want 5 %h", i, CountQ, PCD1, prev + 32'd8);
      end
    end
  endtask

  task automatic test_drain;
    idle_issue(2'd2);
    idle_issue(2'd2);
    checks++;
    if (CountQ !== 4'd1 || ValidD1 !== 1'b1 || ValidD2 !== 1'b0 || InstrD2 !== 32'h13) begin
      errors++;
      $display("FAIL drain_one got count=%0d v1=%b v2=%b i2=%h want 1 1 0 13",
               CountQ, ValidD1, ValidD2, InstrD2);
    end
    idle_issue(2'd2);
    checks++;
    if (CountQ !== 4'd0 || ValidD1 !== 1'b0 || InstrD1 !== 32'h13 || PCD1 !== 32'h0) begin
      errors++;
      $display("FAIL drain_empty got count=%0d v1=%b i1=%h pc1=%h want 0 0 13 0",
               CountQ, ValidD1, InstrD1, PCD1);
    end
    idle_issue(2'd2);
    checks++;
    if (CountQ !== 4'd0 || ValidD1 !== 1'b0 || ReadyF !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty got count=%0d v1=%b ready=%b want 0 0 1", CountQ, ValidD1, ReadyF);
    end
  endtask

  task automatic test_odd;
    logic [31:0] p, q;
    p = next_pc;
    push_pair(2'd0);
    idle_issue(2'd1);
    q = next_pc;
    push_pair(2'd0);
    checks++;
    if (CountQ !== 4'd3 || PCD1 !== p + 32'd4 || PCD2 !== q) begin
      errors++;
      $display("FAIL odd_align got count=%0d pc1=%h pc2=%h want 3 %h %h", CountQ, PCD1, PCD2, p + 32'd4, q);
    end
    idle_issue(2'd3);
    checks++;
    if (CountQ !== 4'd1 || PCD1 !== q + 32'd4) begin
      errors++;
      $display("FAIL issue3 got count=%0d pc1=%h want 1 %h", CountQ, PCD1, q + 32'd4);
    end
    idle_issue(2'd2);
    checks++;
    if (CountQ !== 4'd0) begin
      errors++;
      $display("FAIL clip got count=%0d want 0", CountQ);
    end
  endtask

  task automatic test_flush;
    bit acc;
    repeat (3) push_pair(2'd0);
    checks++;
    if (CountQ !== 4'd6) begin
      errors++;
      $display("FAIL flush_setup got count=%0d want 6", CountQ);
    end
    drive_cycle(1'b1, next_pc, 2'd2, 1'b1, acc);
    checks++;
    if (CountQ !== 4'd0 || ValidD1 !== 1'b0 || ReadyF !== 1'b1) begin
      errors++;
      $display("FAIL flush got count=%0d v1=%b ready=%b want 0 0 1", CountQ, ValidD1, ReadyF);
    end
    next_pc = 32'h1000;
    push_pair(2'd0);
    checks++;
    if (CountQ !== 4'd2 || PCD1 !== 32'h1000 || PCD2 !== 32'h1004) begin
      errors++;
      $display("FAIL post_flush got count=%0d pc1=%h pc2=%h want 2 1000 1004", CountQ, PCD1, PCD2);
    end
    idle_issue(2'd2);
  endtask

  task automatic test_async_reset;
    push_pair(2'd0);
    push_pair(2'd0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ValidD1 !== 1'b0 || ValidD2 !== 1'b0 || CountQ !== 4'd0 || ReadyF !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v1=%b v2=%b count=%0d ready=%b want 0 0 0 1",
               ValidD1, ValidD2, CountQ, ReadyF);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    next_pc = 32'h2000;
    push_pair(2'd0);
    checks++;
    if (CountQ !== 4'd2 || PCD1 !== 32'h2000) begin
      errors++;
      $display("FAIL after_reset got count=%0d pc1=%h want 2 2000", CountQ, PCD1);
    end
    idle_issue(2'd2);
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_fill();
    test_partial_issue();
    test_wrap();
    test_drain();
    test_odd();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
